pc_gen: RTL and testbench
=========================

# pc_gen

Registered program-counter generator for the fetch front end. It holds the current fetch PC and presents it to instruction fetch with a valid/ready handshake. It advances by INST_BYTES on each accepted fetch and redirects to the highest-priority of N_REDIR target channels, such as exception, mret/flush or branch. After a redirect it inserts a configurable bubble so fetch sees no wrong-path PC. Redirect targets are taken as the exact next PC; callers apply no pre-compensation.

## Interface
- XLEN, 64, PC width in bits
- RESET_PC, 64'h0000_0000_8000_0000, PC presented after reset; truncated to XLEN
- INST_BYTES, 4, sequential increment; power of two, ≥2
- N_REDIR, 3, number of redirect channels; bit 0 has highest priority
- REDIR_BUBBLE, 1, cycles with fetch_valid=0 after a redirect; 0 is legal
- CNT_W, 32, width of redirect event counter
---
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- redir_valid  in  N_REDIR  per-channel redirect request, one-cycle pulse semantics
- redir_target  in  N_REDIR*XLEN  channel i target at [i*XLEN +: XLEN]
- fetch_ready  in  1  fetch accepts fetch_pc this cycle
- fetch_valid  out  1  fetch_pc is a valid correct-path PC
- fetch_pc  out  XLEN  current fetch PC (registered)
- redir_sel  out  N_REDIR  one-hot channel of the last accepted redirect (registered)
- redir_cnt  out  CNT_W  count of accepted redirects, wraps modulo 2^CNT_W

## Operation
- States: BOOT, RUN, BUBBLE.
- Reset: state=BOOT, fetch_pc=RESET_PC, fetch_valid=0, redir_sel=0, redir_cnt=0, bubble counter=0.
- BOOT: goes to RUN unconditionally on the next edge, so fetch_valid=1 one cycle after reset deasserts. A redirect in BOOT is handled as in the redirect rule below.
- Priority select: the lowest set index of redir_valid wins. Other channels in the same cycle are dropped; they are not queued.
- Redirect (any state, any value of fetch_ready):
  - fetch_pc <= winning target with bits [log2(INST_BYTES)-1:0] cleared.
  - redir_sel <= one-hot of the winner.
  - redir_cnt <= redir_cnt+1.
  - If REDIR_BUBBLE>0: state <= BUBBLE and counter <= REDIR_BUBBLE-1. Otherwise state <= RUN.
  - A redirect overrides any simultaneous fetch handshake: the current fetch_pc is not advanced and the handshake is considered killed.
- RUN, no redirect: if fetch_valid && fetch_ready, then fetch_pc <= fetch_pc + INST_BYTES, wrapping modulo 2^XLEN. Otherwise fetch_pc holds.
- BUBBLE: fetch_valid=0 and fetch_pc holds.
  - The counter decrements each cycle; at 0, state <= RUN.
  - A new redirect during BUBBLE replaces the target and restarts the counter at REDIR_BUBBLE-1.
- fetch_valid is 1 exactly in RUN. It is a registered state decode, not a function of inputs.
- fetch_pc must be stable while fetch_valid=1 and fetch_ready=0, unless a redirect occurs.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Redirect latency: target on fetch_pc the edge after redir_valid.
  - fetch_valid=1 with that target (REDIR_BUBBLE+1) cycles after the redir_valid cycle, i.e. REDIR_BUBBLE bubble cycles.
- Sequential throughput: one PC per cycle while fetch_ready=1.
- Reset mid-operation overrides everything, including a redirect in the same cycle, and returns all outputs to reset values on the next edge.

## Test plan
- Reset then fetch_ready=1 for 4 cycles:
  - Cycle 0 after reset: fetch_valid=0, fetch_pc=0x80000000.
  - Then fetch_pc goes 0x80000000, 0x80000004, 0x80000008, 0x8000000C with fetch_valid=1.
- Backpressure: fetch_ready=0 for 3 cycles at fetch_pc=0x80000010 -> fetch_pc holds 0x80000010 and fetch_valid stays 1. Raising fetch_ready gives 0x80000014 on the next edge.
- Priority: redir_valid=3'b110, targets ch1=0x1000, ch2=0x2000 -> fetch_pc=0x1000, redir_sel=3'b010, redir_cnt=1. With REDIR_BUBBLE=1, fetch_valid=0 for 1 cycle, then 1 at 0x1000.
- Redirect during bubble (REDIR_BUBBLE=2): ch2 to 0x2000, then the next cycle ch0 to 0x3002 -> fetch_pc=0x3000 (aligned), 2 bubble cycles counted from the second redirect, redir_cnt=2.
- Wrap: redirect to 0xFFFF_FFFF_FFFF_FFFC, then accept 2 fetches -> fetch_pc goes 0xFFFFFFFFFFFFFFFC, then 0x0, then 0x4.
- Reset with simultaneous redir_valid=3'b001 mid-run -> fetch_pc=RESET_PC, fetch_valid=0, redir_cnt=0, redir_sel=0.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential advance on accepted fetches,
// prioritised redirects with a configurable post-redirect bubble.
module pc_gen #(
  parameter int          XLEN         = 64,
  parameter logic [63:0] RESET_PC     = 64'h0000_0000_8000_0000,
  parameter int          INST_BYTES   = 4,
  parameter int          N_REDIR      = 3,
  parameter int          REDIR_BUBBLE = 1,
  parameter int          CNT_W        = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REDIR-1:0]       redir_valid,
  input  logic [N_REDIR*XLEN-1:0]  redir_target,
  input  logic                     fetch_ready,
  output logic                     fetch_valid,
  output logic [XLEN-1:0]          fetch_pc,
  output logic [N_REDIR-1:0]       redir_sel,
  output logic [CNT_W-1:0]         redir_cnt
);

  localparam int BW = (REDIR_BUBBLE > 1) ? $clog2(REDIR_BUBBLE) : 1;
  localparam logic [BW-1:0] BUB_INIT = (REDIR_BUBBLE > 0) ? BW'(REDIR_BUBBLE - 1) : BW'(0);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));
  localparam logic [XLEN-1:0] PC_INIT = XLEN'(RESET_PC);
  localparam logic [N_REDIR-1:0] ONE_HOT0 = N_REDIR'(1);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t               state_r;
  logic [BW-1:0]        bubble_cnt_r;
  logic [N_REDIR-1:0]   win_onehot_s;
  logic [XLEN-1:0]      win_target_s;
  logic                 redir_any_s;

  // Lowest-index redirect channel wins; scanning downward lets it overwrite.
  always_comb begin
    win_onehot_s = {N_REDIR{1'b0}};
    win_target_s = {XLEN{1'b0}};
    redir_any_s  = |redir_valid;
    for (int i = N_REDIR - 1; i >= 0; i--) begin
      win_onehot_s = redir_valid[i] ? (ONE_HOT0 << i) : win_onehot_s;
      win_target_s = redir_valid[i] ? redir_target[i*XLEN +: XLEN] : win_target_s;
    end
  end

  // PC state machine; fetch_valid is registered as "next state is RUN".
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= BOOT;
      fetch_pc     <= PC_INIT;
      fetch_valid  <= 1'b0;
      redir_sel    <= {N_REDIR{1'b0}};
      redir_cnt    <= {CNT_W{1'b0}};
      bubble_cnt_r <= BW'(0);
    end else if (redir_any_s) begin
      // A redirect kills any simultaneous handshake in every state.
      fetch_pc     <= win_target_s & ALIGN_MASK;
      redir_sel    <= win_onehot_s;
      redir_cnt    <= redir_cnt + CNT_W'(1);
      bubble_cnt_r <= BUB_INIT;
      if (REDIR_BUBBLE > 0) begin
        state_r     <= BUBBLE;
        fetch_valid <= 1'b0;
      end else begin
        state_r     <= RUN;
        fetch_valid <= 1'b1;
      end
    end else begin
      case (state_r)
        BOOT: begin
          state_r     <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          fetch_valid <= 1'b1;
          if (fetch_valid && fetch_ready) begin
            fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
          end else begin
            fetch_pc <= fetch_pc;
          end
        end
        BUBBLE: begin
          if (bubble_cnt_r == BW'(0)) begin
            state_r     <= RUN;
            fetch_valid <= 1'b1;
          end else begin
            bubble_cnt_r <= bubble_cnt_r - BW'(1);
            fetch_valid  <= 1'b0;
          end
        end
        default: begin
          state_r     <= BOOT;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one instance with a 1-cycle bubble, one with 2.
module tb_pc_gen;

  logic         clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset, fetch_ready, fetch_valid;
  logic [2:0]   redir_valid, redir_sel;
  logic [191:0] redir_target;
  logic [63:0]  fetch_pc;
  logic [31:0]  redir_cnt;

  logic         reset_b, fetch_ready_b, fetch_valid_b;
  logic [2:0]   redir_valid_b, redir_sel_b;
  logic [191:0] redir_target_b;
  logic [63:0]  fetch_pc_b;
  logic [31:0]  redir_cnt_b;

  int checks = 0;
  int errors = 0;

  pc_gen #(.REDIR_BUBBLE(1)) dut (
    .clock(clock), .reset(reset), .redir_valid(redir_valid),
    .redir_target(redir_target), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .redir_sel(redir_sel), .redir_cnt(redir_cnt)
  );

  pc_gen #(.REDIR_BUBBLE(2)) dut_b (
    .clock(clock), .reset(reset_b), .redir_valid(redir_valid_b),
    .redir_target(redir_target_b), .fetch_ready(fetch_ready_b),
    .fetch_valid(fetch_valid_b), .fetch_pc(fetch_pc_b),
    .redir_sel(redir_sel_b), .redir_cnt(redir_cnt_b)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; fetch_ready = 1'b0; redir_valid = 3'b000; redir_target = '0;
    reset_b = 1'b1; fetch_ready_b = 1'b0; redir_valid_b = 3'b000; redir_target_b = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", {63'd0, fetch_valid}, 64'd0);
    check("rst_pc", fetch_pc, 64'h8000_0000);
    check("rst_sel", {61'd0, redir_sel}, 64'd0);
    check("rst_cnt", {32'd0, redir_cnt}, 64'd0);
    fetch_ready = 1'b1;

    // Sequential run out of BOOT
    tick();
    check("boot_valid", {63'd0, fetch_valid}, 64'd1);
    check("seq0", fetch_pc, 64'h8000_0000);
    tick(); check("seq1", fetch_pc, 64'h8000_0004);
    tick(); check("seq2", fetch_pc, 64'h8000_0008);
    tick(); check("seq3", fetch_pc, 64'h8000_000C);
    tick(); check("seq4", fetch_pc, 64'h8000_0010);

    // Backpressure holds the PC with valid high
    fetch_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_pc", fetch_pc, 64'h8000_0010);
      check("bp_valid", {63'd0, fetch_valid}, 64'd1);
    end
    fetch_ready = 1'b1;
    tick(); check("bp_release", fetch_pc, 64'h8000_0014);

    // Priority: ch1 beats ch2
    redir_valid = 3'b110;
    redir_target[64 +: 64] = 64'h1000;
    redir_target[128 +: 64] = 64'h2000;
    tick();
    redir_valid = 3'b000;
    check("prio_pc", fetch_pc, 64'h1000);
    check("prio_sel", {61'd0, redir_sel}, 64'h2);
    check("prio_cnt", {32'd0, redir_cnt}, 64'd1);
    check("prio_bubble", {63'd0, fetch_valid}, 64'd0);
    tick();
    check("prio_valid", {63'd0, fetch_valid}, 64'd1);
    check("prio_hold", fetch_pc, 64'h1000);
    tick(); check("prio_adv", fetch_pc, 64'h1004);

    // Wrap at the top of the address space
    redir_valid = 3'b001;
    redir_target[0 +: 64] = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redir_valid = 3'b000;
    check("wrap_tgt", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_sel", {61'd0, redir_sel}, 64'h1);
    check("wrap_cnt", {32'd0, redir_cnt}, 64'd2);
    tick();
    check("wrap_valid", {63'd0, fetch_valid}, 64'd1);
    tick(); check("wrap_0", fetch_pc, 64'h0);
    tick(); check("wrap_4", fetch_pc, 64'h4);

    // Reset beats a simultaneous redirect
    reset = 1'b1;
    redir_valid = 3'b001;
    redir_target[0 +: 64] = 64'h5000;
    tick();
    reset = 1'b0; redir_valid = 3'b000;
    check("rr_pc", fetch_pc, 64'h8000_0000);
    check("rr_valid", {63'd0, fetch_valid}, 64'd0);
    check("rr_cnt", {32'd0, redir_cnt}, 64'd0);
    check("rr_sel", {61'd0, redir_sel}, 64'd0);

    // Two-cycle bubble instance: redirect during bubble restarts it
    reset_b = 1'b0; fetch_ready_b = 1'b1;
    tick();
    check("b_boot", {63'd0, fetch_valid_b}, 64'd1);
    redir_valid_b = 3'b100;
    redir_target_b[128 +: 64] = 64'h2000;
    tick();
    check("b_first", fetch_pc_b, 64'h2000);
    redir_valid_b = 3'b001;
    redir_target_b[0 +: 64] = 64'h3002;
    tick();
    redir_valid_b = 3'b000;
    check("b_align", fetch_pc_b, 64'h3000);
    check("b_cnt", {32'd0, redir_cnt_b}, 64'd2);
    check("b_sel", {61'd0, redir_sel_b}, 64'h1);
    check("b_bub1", {63'd0, fetch_valid_b}, 64'd0);
    tick();
    check("b_bub2", {63'd0, fetch_valid_b}, 64'd0);
    check("b_bub2_pc", fetch_pc_b, 64'h3000);
    tick();
    check("b_valid", {63'd0, fetch_valid_b}, 64'd1);
    check("b_valid_pc", fetch_pc_b, 64'h3000);
    tick(); check("b_adv", fetch_pc_b, 64'h3004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
